roberto_seq_uc: RTL and testbench

Parametrised sequencing control unit for the sensor/serial/servo datapath. On `jogar` it runs one full round:
- clears the datapath, triggers one measurement and waits for the one-second tick;
- transmits BYTES_PER_SENSOR bytes for each of N_SENSORS sensors;
- receives N_RECV bytes, loading each into its own register.

Successor to the fixed 3-sensor, 4-byte, 3-receive unit. The sensor, byte and receive index counters are internal and are driven out as select buses. It also adds an optional receive timeout with an error exit.

---
 rtl/roberto_uc_pkg.sv | 15 +
 rtl/roberto_seq_uc_contador_idx.sv | 17 +
 rtl/roberto_seq_uc.sv | 81 ++++++++
 tb/tb_roberto_seq_uc.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/roberto_uc_pkg.sv
// roberto_uc_pkg: state codes, debug error code and index-bus width helper for roberto_seq_uc
package roberto_uc_pkg;
  localparam logic [3:0] S_IDLE = 4'd0, S_RESET = 4'd1, S_MEDIR = 4'd2, S_ESP_SEG = 4'd3,
                         S_ENVIA = 4'd4, S_PROX_BYTE = 4'd5, S_PROX_SENSOR = 4'd6,
                         S_ESP_RX = 4'd7, S_PROX_RX = 4'd8, S_FINAL = 4'd9, S_ERRO = 4'd10;
  localparam logic [3:0] DB_ILEGAL = 4'b1111;
  typedef enum logic [3:0] {
    IDLE = S_IDLE, RESET = S_RESET, MEDIR = S_MEDIR, ESP_SEG = S_ESP_SEG, ENVIA = S_ENVIA,
    PROX_BYTE = S_PROX_BYTE, PROX_SENSOR = S_PROX_SENSOR, ESP_RX = S_ESP_RX,
    PROX_RX = S_PROX_RX, FINAL = S_FINAL, ERRO = S_ERRO
  } estado_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/roberto_seq_uc_contador_idx.sv
// contador_idx: modulo-N index counter with clear, advance and wrap flag
module contador_idx import roberto_uc_pkg::*; #(
  parameter int N = 2,
  localparam int W = idx_w(N)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [W-1:0] q,
  output logic         fim
);
  assign fim = q == W'(N - 1);
  always_ff @(posedge clock)
    if (reset || zera) q <= '0;
    else if (conta) q <= fim ? '0 : q + 1'b1;
endmodule

// File: rtl/roberto_seq_uc.sv
// roberto_seq_uc: measure / transmit / receive round sequencer; define RX_TIMEOUT_EN
// to bound each received byte by RX_TIMEOUT_CYC cycles with an exit through ERRO.
module roberto_seq_uc import roberto_uc_pkg::*; #(
  parameter int N_SENSORS        = 3,
  parameter int BYTES_PER_SENSOR = 4,
  parameter int N_RECV           = 3,
  parameter int RX_TIMEOUT_CYC   = 50_000_000
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             jogar,
  input  logic                             pronto_seg,
  input  logic                             pronto_serial,
  input  logic                             pronto_recepcao,
  output logic                             zera_sensor,
  output logic                             zera_serial,
  output logic                             zera_seg,
  output logic                             zera_recepcao,
  output logic                             zera_servos,
  output logic                             medir,
  output logic                             cont_seg,
  output logic                             partida_tx,
  output logic [idx_w(N_SENSORS)-1:0]      sensor_sel,
  output logic [idx_w(BYTES_PER_SENSOR)-1:0] byte_sel,
  output logic [N_RECV-1:0]                carrega_reg,
  output logic                             pronto,
  output logic                             erro,
  output logic [3:0]                       db_estado
);
  estado_t estado, prox;
  logic fim_s, fim_b, fim_r, zera_idx, estouro;
  logic [idx_w(N_RECV)-1:0] rx_idx;
  assign zera_idx = estado == RESET || estado == ERRO;
  contador_idx #(.N(N_SENSORS)) u_sensor (
    .clock, .reset, .zera(zera_idx), .conta(estado == PROX_SENSOR), .q(sensor_sel), .fim(fim_s)
  );
  contador_idx #(.N(BYTES_PER_SENSOR)) u_byte (
    .clock, .reset, .zera(zera_idx), .conta(estado == PROX_BYTE), .q(byte_sel), .fim(fim_b)
  );
  contador_idx #(.N(N_RECV)) u_rx (
    .clock, .reset, .zera(zera_idx), .conta(estado == PROX_RX), .q(rx_idx), .fim(fim_r)
  );
`ifdef RX_TIMEOUT_EN
  logic [31:0] tmo;
  always_ff @(posedge clock)
    if (reset || estado != ESP_RX) tmo <= '0;
    else tmo <= tmo + 1'b1;
  assign estouro = tmo == 32'(RX_TIMEOUT_CYC - 1);
  assign erro = estado == ERRO;
`else
  logic unused_tmo;
  assign unused_tmo = RX_TIMEOUT_CYC[0];
  assign estouro = 1'b0;
  assign erro = 1'b0;
`endif
  // a byte that arrives on the timeout cycle still counts as received
  always_comb begin
    prox = IDLE;
    case (estado)
      IDLE:        prox = jogar ? RESET : IDLE;
      RESET:       prox = MEDIR;
      MEDIR:       prox = ESP_SEG;
      ESP_SEG:     prox = pronto_seg ? ENVIA : ESP_SEG;
      ENVIA:       prox = pronto_serial ? PROX_BYTE : ENVIA;
      PROX_BYTE:   prox = fim_b ? PROX_SENSOR : ENVIA;
      PROX_SENSOR: prox = fim_s ? ESP_RX : ENVIA;
      ESP_RX:      prox = pronto_recepcao ? PROX_RX : estouro ? ERRO : ESP_RX;
      PROX_RX:     prox = fim_r ? FINAL : ESP_RX;
      default:     prox = IDLE;
    endcase
  end
  always_ff @(posedge clock)
    estado <= reset ? IDLE : prox;
  assign {zera_sensor, zera_serial, zera_seg, zera_recepcao, zera_servos} = {5{estado == RESET}};
  assign medir       = estado == MEDIR;
  assign cont_seg    = estado == ESP_SEG;
  assign partida_tx  = estado == ENVIA;
  assign pronto      = estado == FINAL;
  assign carrega_reg = (estado == PROX_RX) ? N_RECV'(1) << rx_idx : '0;
  assign db_estado   = (estado > ERRO) ? DB_ILEGAL : estado;
endmodule

// File: tb/tb_roberto_seq_uc.sv
// tb_roberto_seq_uc: trace-model bench for roberto_seq_uc (default, 1/1/1 and short-timeout builds)
module tb_roberto_seq_uc;
  typedef struct packed {
    logic [3:0] st; logic [1:0] s; logic [1:0] b; logic [2:0] ld; logic [4:0] z;
    logic medir, cseg, ptx, pr, er;
  } exp_t;

  logic clock = 0, reset = 1, run = 0;
  always #5 clock = ~clock;
  int n_chk = 0, n_fail = 0;

  logic jogar0 = 0, ps0 = 0, pt0 = 0;
  logic zs0, zt0, zg0, zr0, zv0, medir0, cseg0, ptx0, pronto0, erro0;
  logic [1:0] ss0, bs0; logic [2:0] ld0; logic [3:0] db0;
  roberto_seq_uc u0 (
    .clock(clock), .reset(reset), .jogar(jogar0), .pronto_seg(ps0), .pronto_serial(pt0),
    .pronto_recepcao(1'b1), .zera_sensor(zs0), .zera_serial(zt0), .zera_seg(zg0),
    .zera_recepcao(zr0), .zera_servos(zv0), .medir(medir0), .cont_seg(cseg0),
    .partida_tx(ptx0), .sensor_sel(ss0), .byte_sel(bs0), .carrega_reg(ld0),
    .pronto(pronto0), .erro(erro0), .db_estado(db0)
  );

  logic jogar1 = 0;
  logic zs1, zt1, zg1, zr1, zv1, medir1, cseg1, ptx1, pronto1, erro1, ss1, bs1, ld1;
  logic [3:0] db1;
  roberto_seq_uc #(.N_SENSORS(1), .BYTES_PER_SENSOR(1), .N_RECV(1)) u1 (
    .clock(clock), .reset(reset), .jogar(jogar1), .pronto_seg(1'b1), .pronto_serial(1'b1),
    .pronto_recepcao(1'b1), .zera_sensor(zs1), .zera_serial(zt1), .zera_seg(zg1),
    .zera_recepcao(zr1), .zera_servos(zv1), .medir(medir1), .cont_seg(cseg1),
    .partida_tx(ptx1), .sensor_sel(ss1), .byte_sel(bs1), .carrega_reg(ld1),
    .pronto(pronto1), .erro(erro1), .db_estado(db1)
  );

  logic jogar2 = 0, prx2 = 0, erro2, pronto2;
  logic [3:0] db2; logic [10:0] unused_u2;
  roberto_seq_uc #(.N_SENSORS(1), .BYTES_PER_SENSOR(1), .N_RECV(1), .RX_TIMEOUT_CYC(10)) u2 (
    .clock(clock), .reset(reset), .jogar(jogar2), .pronto_seg(1'b1), .pronto_serial(1'b1),
    .pronto_recepcao(prx2), .zera_sensor(unused_u2[0]), .zera_serial(unused_u2[1]),
    .zera_seg(unused_u2[2]), .zera_recepcao(unused_u2[3]), .zera_servos(unused_u2[4]),
    .medir(unused_u2[5]), .cont_seg(unused_u2[6]), .partida_tx(unused_u2[7]),
    .sensor_sel(unused_u2[8]), .byte_sel(unused_u2[9]), .carrega_reg(unused_u2[10]),
    .pronto(pronto2), .erro(erro2), .db_estado(db2)
  );

  exp_t o0, o1;
  assign o0 = {db0, ss0, bs0, ld0, {zs0, zt0, zg0, zr0, zv0}, medir0, cseg0, ptx0, pronto0, erro0};
  assign o1 = {db1, 1'b0, ss1, 1'b0, bs1, 2'b0, ld1, {zs1, zt1, zg1, zr1, zv1},
               medir1, cseg1, ptx1, pronto1, erro1};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected outputs of one state visit, straight from the state table
  function automatic exp_t mk(input int st, input int s, input int b, input int ld);
    exp_t e;
    e.st = 4'(st); e.s = 2'(s); e.b = 2'(b); e.ld = 3'(ld);
    e.z = (st == 1) ? 5'h1f : 5'h00;
    e.medir = st == 2; e.cseg = st == 3; e.ptx = st == 4; e.pr = st == 9; e.er = st == 10;
    return e;
  endfunction

  exp_t tq[$], q0[$], q1[$];
  task automatic build(input int ns, input int nb, input int nr, input int ds, input int dt);
    tq.delete();
    tq.push_back(mk(0, 0, 0, 0));
    tq.push_back(mk(1, 0, 0, 0));
    tq.push_back(mk(2, 0, 0, 0));
    repeat (ds) tq.push_back(mk(3, 0, 0, 0));
    for (int s = 0; s < ns; s++) begin
      for (int b = 0; b < nb; b++) begin
        repeat (dt) tq.push_back(mk(4, s, b, 0));
        tq.push_back(mk(5, s, b, 0));
      end
      tq.push_back(mk(6, s, 0, 0));
    end
    for (int r = 0; r < nr; r++) begin
      tq.push_back(mk(7, 0, 0, 0));
      tq.push_back(mk(8, 0, 0, 1 << r));
    end
    tq.push_back(mk(9, 0, 0, 0));
  endtask

  int dseg = 1, dtx = 1, cs = 0, ct = 0;
  always @(negedge clock) begin
    cs = cseg0 ? cs + 1 : 0;
    ps0 = cseg0 && cs >= dseg;
    ct = ptx0 ? ct + 1 : 0;
    pt0 = ptx0 && ct >= dtx;
  end

  logic [3:0] tx_log[$], log1[$];
  logic [2:0] ld_log[$];
  logic ptx_d = 0;
  logic [3:0] p1 = 0;
  int cyc = 0, t0 = 0, lat = 0, n_pr = 0, n_ptx = 0;
  always @(negedge clock) if (run) begin
    exp_t e0, e1;
    e0 = '0; e1 = '0;
    if (q0.size() != 0) e0 = q0.pop_front();
    if (q1.size() != 0) e1 = q1.pop_front();
    chk("u0_cycle", 32'(o0), 32'(e0));
    chk("u1_cycle", 32'(o1), 32'(e1));
    if (ptx0 && !ptx_d) tx_log.push_back({ss0, bs0});
    ptx_d = ptx0;
    if (ptx0) n_ptx++;
    if (ld0 != 0) ld_log.push_back(ld0);
    if (db0 == 4'd1) t0 = cyc;
    if (pronto0) begin n_pr++; lat = cyc - t0 + 1; end
    if (db1 != 0 || p1 != 0) log1.push_back(db1);
    p1 = db1;
    cyc++;
  end

  task automatic step;
    @(posedge clock); #1;
  endtask
  task automatic clr;
    tx_log.delete(); ld_log.delete(); log1.delete(); n_pr = 0; n_ptx = 0; lat = 0;
  endtask
  task automatic go(input int ds, input int dt, input bit with1);
    step;
    dseg = ds; dtx = dt;
    build(3, 4, 3, ds, dt); q0 = tq; jogar0 = 1;
    if (with1) begin build(1, 1, 1, 1, 1); q1 = tq; jogar1 = 1; end
    step;
    jogar0 = 0; jogar1 = 0;
  endtask
  task automatic drain;
    for (int i = 0; i < 3000 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clock);
    repeat (2) step;
  endtask
  task automatic go2;
    step; jogar2 = 1; step; jogar2 = 0;
    for (int i = 0; i < 50 && db2 != 4'd7; i++) step;
    chk("u2_reach_rx", 32'(db2), 32'd7);
  endtask

  logic [3:0] exp_log1 [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
  logic [2:0] exp_ld [3] = '{3'b001, 3'b010, 3'b100};

  initial begin
    int n;
    repeat (3) @(posedge clock); #1;
    chk("rst_u0", 32'(o0), 32'd0);
    chk("rst_u1", 32'(o1), 32'd0);
    chk("rst_u2", {26'd0, db2, erro2, pronto2}, 32'd0);
    run = 1; reset = 0;

    // instant handshakes on the default and the 1/1/1 builds
    clr; go(1, 1, 1); drain;
    chk("t1_latency", 32'(lat), 32'd37);
    chk("t1_pronto_cycles", 32'(n_pr), 32'd1);
    chk("t1_tx_entries", 32'(tx_log.size()), 32'd12);
    for (int i = 0; i < 12 && i < tx_log.size(); i++)
      chk("t1_tx_sel", 32'(tx_log[i]), {28'd0, 2'(i / 4), 2'(i % 4)});
    chk("t1_loads", 32'(ld_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < ld_log.size(); i++) chk("t1_load_hot", 32'(ld_log[i]), 32'(exp_ld[i]));
    chk("u1_seq_len", 32'(log1.size()), 32'd10);
    for (int i = 0; i < 10 && i < log1.size(); i++) chk("u1_seq", 32'(log1[i]), 32'(exp_log1[i]));

    // slow serial link plus a stray jogar mid-round
    clr; go(1, 7, 0);
    repeat (20) step;
    jogar0 = 1; step; jogar0 = 0;
    drain;
    chk("t3_latency", 32'(lat), 32'd109);
    chk("t3_ptx_cycles", 32'(n_ptx), 32'd84);
    chk("t3_tx_entries", 32'(tx_log.size()), 32'd12);

    // reset while sending sensor 1 byte 2, then restart
    clr; go(1, 1, 0);
    for (int i = 0; i < 100 && !(db0 == 4'd4 && ss0 == 2'd1 && bs0 == 2'd2); i++) step;
    chk("abort_reach", {24'd0, db0, ss0, bs0}, {24'd0, 4'd4, 2'd1, 2'd2});
    while (q0.size() > 1) q0.delete(q0.size() - 1);
    reset = 1; step;
    chk("abort_state", 32'(o0), 32'd0);
    reset = 0;
    repeat (3) step;
    chk("abort_no_pronto", 32'(n_pr), 32'd0);
    clr; go(1, 1, 0); drain;
    chk("restart_first_tx", tx_log.size() != 0 ? 32'(tx_log[0]) : 32'hff, 32'd0);
    chk("restart_latency", 32'(lat), 32'd37);

    // receive timeout build
    go2;
    n = 0;
    while (db2 == 4'd7 && n < 40) begin n++; step; end
`ifdef RX_TIMEOUT_EN
    chk("to_cycles", 32'(n), 32'd10);
    chk("to_state", {28'd0, db2}, 32'd10);
    chk("to_erro_pronto", {30'd0, erro2, pronto2}, 32'b10);
    step;
    chk("to_idle", {27'd0, db2, erro2}, 32'd0);
    go2;
    repeat (9) step;
    chk("late_still_rx", {28'd0, db2}, 32'd7);
    prx2 = 1; step; prx2 = 0;
    chk("late_prox_rx", {27'd0, db2, erro2}, {27'd0, 4'd8, 1'b0});
`else
    chk("wait_forever", 32'(n), 32'd40);
    chk("wait_no_erro", {31'd0, erro2}, 32'd0);
    prx2 = 1; step; prx2 = 0;
    chk("wait_prox_rx", {28'd0, db2}, 32'd8);
`endif
    step;
    chk("u2_final", {27'd0, db2, pronto2}, {27'd0, 4'd9, 1'b1});
    step;
    chk("u2_idle", {27'd0, db2, erro2}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, failures so far %0d", n_fail);
    $fatal(1);
  end
endmodule
